// File: rtl/miinst_queue.sv
// miinst_queue: micro-instruction queue between the x86 front-end decoder and
// the decode phase. It is a circular buffer that accepts up to ENQ_N
// micro-instructions per cycle and presents the oldest entry combinationally.
// Optional feature macro: MIQ_BYPASS_EN. When it is defined, an enqueue into an
// empty queue is forwarded straight to the head in the same cycle.

package miinst_pkg;

  typedef enum logic [3:0] {
    MIOP_NOP    = 4'd0,
    MIOP_ALU    = 4'd1,
    MIOP_LOAD   = 4'd2,
    MIOP_STORE  = 4'd3,
    MIOP_BRANCH = 4'd4,
    MIOP_MOVE   = 4'd5
  } miop_t;

  typedef struct packed {
    miop_t       op;
    logic [4:0]  dst;
    logic [4:0]  src1;
    logic [4:0]  src2;
    logic [15:0] imm;
  } miinst_t;

endpackage

module miinst_queue
  import miinst_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ENQ_N = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  miinst_t [ENQ_N-1:0]          enq_miinst,
  input  logic    [ENQ_N-1:0]          enq_valid,
  output logic                         enq_ready,
  output miinst_t                      deq_miinst_head,
  output logic                         deq_valid,
  input  logic                         deq_ready,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  miinst_t       mem [DEPTH];

  logic          empty;
  logic          bypass_hit;
  logic          skip_lane0;
  logic          do_deq;
  logic [CW-1:0] n_wr;
  logic [ENQ_N-1:0] lane_wr;
  logic [PW-1:0] lane_slot [ENQ_N];

  assign empty = (count == '0);

  // Readiness looks only at registered occupancy, so a same-cycle dequeue
  // never opens room for an enqueue until the following cycle.
  assign enq_ready = (DEPTH - int'(count)) >= ENQ_N;

`ifdef MIQ_BYPASS_EN
  assign bypass_hit = empty && enq_valid[0] && !flush;
`else
  assign bypass_hit = 1'b0;
`endif

  // A bypassed lane 0 that the consumer takes this cycle is never stored.
  assign skip_lane0 = bypass_hit && deq_ready;

  assign deq_valid  = !empty || bypass_hit;

  // Only a stored entry can be popped; the bypassed entry is handled above.
  assign do_deq     = deq_ready && !empty;

  // Compact valid lanes onto consecutive slots starting at the write pointer.
  always_comb begin
    n_wr    = '0;
    lane_wr = '0;
    for (int i = 0; i < ENQ_N; i++) begin
      lane_slot[i] = wr_ptr + n_wr[PW-1:0];
      if (enq_ready && !flush && enq_valid[i] && !(i == 0 && skip_lane0)) begin
        lane_wr[i] = 1'b1;
        n_wr       = n_wr + CW'(1);
      end
    end
  end

  // Storage has no reset; its contents only matter behind a valid count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_N; i++) begin
      if (lane_wr[i]) begin
        mem[lane_slot[i]] <= enq_miinst[i];
      end
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over enqueue and dequeue.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(do_deq);
      wr_ptr <= wr_ptr + n_wr[PW-1:0];
      count  <= count + n_wr - CW'(do_deq);
    end
  end

  // Head is combinational from storage, or the bypassed lane when empty.
  always_comb begin
    deq_miinst_head = '0;
    if (!empty) begin
      deq_miinst_head = mem[rd_ptr];
    end else if (bypass_hit) begin
      deq_miinst_head = enq_miinst[0];
    end
  end

endmodule
